sr_reg_bank: RTL
================

SR_REG_BANK -- requirements
Module: sr_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of independent SR channels (1..64).
REQ-002 SHALL have parameter CONFLICT_MODE, default 0, behaviour for S=R=1: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
REQ-003 SHALL have parameter CNT_W, default 8, width of conflict counter.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port en  input  1  update enable; s/r ignored when low.
REQ-007 SHALL have port s  input  WIDTH  per-channel set request.
REQ-008 SHALL have port r  input  WIDTH  per-channel reset request.
REQ-009 SHALL have port clr_flag  input  1  clears conflict flag and counter.
REQ-010 SHALL have port q  output  WIDTH  registered channel state.
REQ-011 SHALL have port qbar  output  WIDTH  complement of q.
REQ-012 SHALL have port changed  output  WIDTH  registered one-cycle pulse per channel whose q changed at the last edge.
REQ-013 SHALL have port conflict  output  1  sticky flag, any S=R=1 seen while enabled.
REQ-014 SHALL have port conflict_cnt  output  CNT_W  saturating conflict-cycle count (present only with SR_CONFLICT_CNT_EN).

Function
REQ-015 SHALL, per channel with en=1 at an edge: s,r=00 hold; 10 q=1; 01 q=0; 11 per CONFLICT_MODE.
REQ-016 SHALL in toggle mode (3) invert q of each channel with s=r=1.
REQ-017 SHALL treat CONFLICT_MODE values above 3 as mode 0 (hold).
REQ-018 SHALL hold q, conflict and conflict_cnt unchanged when en=0, and drive changed=0 on that edge.
REQ-019 SHALL drive qbar combinationally as bitwise NOT of q at all times, including during reset.
REQ-020 SHALL set changed[i]=1 for exactly one cycle after an edge at which q[i] took a new value; else 0.
REQ-021 SHALL have latency of one edge from s/r/en sampled to q, changed, conflict update.
REQ-022 SHALL set conflict at an edge where en=1 and (s AND r) is non-zero; conflict remains set until clr_flag or rst.
REQ-023 SHALL, on simultaneous clr_flag=1 and a new conflict, leave conflict=1 (set wins).
REQ-024 SHALL increment conflict_cnt by one per enabled edge with any conflicting channel, regardless of how many channels conflict.
REQ-025 SHALL saturate conflict_cnt at all-ones; no wrap-around.
REQ-026 SHALL, on clr_flag=1 with a simultaneous conflict, load conflict_cnt=1; with no conflict, load 0.
REQ-027 SHALL apply clr_flag regardless of en.

Reset
REQ-028 SHALL, at an edge with rst=1, force q=0, changed=0, conflict=0, conflict_cnt=0; qbar thus all-ones.
REQ-029 SHALL give rst priority over en, s, r and clr_flag, including mid-operation.
REQ-030 SHALL not produce a changed pulse for the reset-induced transition of q.

Configuration
REQ-031 SHALL compile conflict_cnt port and counter logic in only when macro SR_CONFLICT_CNT_EN is defined.
REQ-032 SHALL, without SR_CONFLICT_CNT_EN, omit conflict_cnt entirely; all other behaviour identical, conflict flag retained.

Verification (WIDTH=8, CNT_W=4, counter enabled)
REQ-033 SHALL cover: rst=1 one edge -> q=0x00, qbar=0xFF, changed=0x00, conflict=0, conflict_cnt=0.
REQ-034 SHALL cover: en=1, s=0x0F, r=0x00, then s=0x00, r=0x03 -> q=0x0F with changed=0x0F, then q=0x0C with changed=0x03, then changed=0x00.
REQ-035 SHALL cover: each CONFLICT_MODE 0..3 from q=0xAA, s=r=0xFF -> q=0xAA, 0xFF, 0x00, 0x55 respectively; conflict=1, conflict_cnt=1.
REQ-036 SHALL cover: en=0, s=0xFF, r=0xFF for 3 edges -> q, conflict, conflict_cnt unchanged, changed=0x00.
REQ-037 SHALL cover: 20 consecutive conflicting enabled edges -> conflict_cnt saturates at 15; then clr_flag with conflict -> conflict=1, conflict_cnt=1; clr_flag alone -> 0, 0.
REQ-038 SHALL cover: rst=1 asserted with s=0xFF, en=1, clr_flag=1 -> reset values of REQ-028, changed=0x00 on next cycle.

Source files
------------

// File: rtl/sr_reg_bank.sv
// sr_reg_bank: a bank of WIDTH independent registered SR flip-flops with
// conflict detection. Each set/reset pair is sampled on the rising edge of clk
// while en is high, and q updates one edge later.
// When both s and r are high, CONFLICT_MODE decides the result: 0 = hold,
// 1 = set wins, 2 = reset wins, 3 = toggle. Values above 3 behave as hold.
// Optional macro SR_CONFLICT_CNT_EN adds a saturating conflict-cycle counter
// and its conflict_cnt port.
module sr_reg_bank #(
  parameter int WIDTH         = 8,
  parameter int CONFLICT_MODE = 0,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] changed,
  output logic             conflict
`ifdef SR_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  // Out-of-range modes collapse to hold so the decode below stays four-way.
  localparam int EFF_MODE = (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) ? 0 : CONFLICT_MODE;

  // Reject parameter values that make no sense for this bank.
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("sr_reg_bank: WIDTH must be in 1..64");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("sr_reg_bank: CNT_W must be at least 1");
  end

  logic [WIDTH-1:0] q_next;
  logic             conflict_hit;

  // Per-channel next-state decode of the SR request pair.
  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({s[i], r[i]})
        2'b00: q_next[i] = q[i];
        2'b10: q_next[i] = 1'b1;
        2'b01: q_next[i] = 1'b0;
        default: begin
          case (EFF_MODE)
            1:       q_next[i] = 1'b1;
            2:       q_next[i] = 1'b0;
            3:       q_next[i] = ~q[i];
            default: q_next[i] = q[i];
          endcase
        end
      endcase
    end
  end

  // A conflict only counts when the bank is actually updating.
  assign conflict_hit = en && ((s & r) != '0);

  // The complement is combinational, so it tracks q through reset as well.
  assign qbar = ~q;

  // Channel state and one-cycle change pulses. Reset suppresses the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      changed <= '0;
    end else if (en) begin
      q       <= q_next;
      changed <= q_next ^ q;
    end else begin
      changed <= '0;
    end
  end

  // Sticky conflict flag. A new conflict beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict <= 1'b0;
    end else if (clr_flag) begin
      conflict <= conflict_hit;
    end else if (conflict_hit) begin
      conflict <= 1'b1;
    end
  end

`ifdef SR_CONFLICT_CNT_EN
  // Saturating count of enabled edges with at least one conflicting channel.
  // A clear that coincides with a conflict restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (clr_flag) begin
      conflict_cnt <= conflict_hit ? CNT_W'(1) : '0;
    end else if (conflict_hit && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
